dmac_request_arbiter: RTL and testbench

- Control stage directly upstream of the DMAC main datapath.
- Latches peripheral DMA requests and selects one channel at a time by fixed priority.
- Arbitrates for the AHB bus.
- Drives the datapath's channel enables and channel-select strobe, holds them until the datapath raises irq, then acknowledges the requester.

---
 rtl/dmac_request_arbiter.sv | 134 +++++++++++++
 tb/tb_dmac_request_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmac_request_arbiter.sv
// Request latch, channel arbiter and AHB bus-request FSM ahead of the DMAC datapath.
// Optional DMAC_ARB_ROUND_ROBIN_EN: alternate channels when both are pending.
module dmac_request_arbiter #(
    parameter int GRANT_TIMEOUT = 16,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dma_req,
    input  logic       c_config,
    input  logic       irq,
    input  logic       hgrant,
    output logic       hbusreq,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic       con_en,
    output logic       con_sel,
    output logic [1:0] dma_ack,
    output logic       busy,
    output logic       grant_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_BUS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam bit              TO_EN    = (GRANT_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);

    state_t           state;
    logic [1:0]       pending;
    logic [1:0]       clr;
    logic [CNT_W-1:0] cnt;
    logic             winner;

`ifdef DMAC_ARB_ROUND_ROBIN_EN
    logic last_served;

    always_comb begin
        winner = ~pending[0];
        if (pending == 2'b11)
            winner = ~last_served;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_served <= 1'b0;
        else if (state == DONE)
            last_served <= con_sel;
    end
`else
    always_comb begin
        winner = ~pending[0];
    end
`endif

    // Served channel is released in DONE; a fresh request on the same edge keeps it pending.
    always_comb begin
        clr = 2'b00;
        if (state == DONE)
            clr = con_sel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 2'b00;
        else
            pending <= (pending & ~clr) | dma_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hbusreq      <= 1'b0;
            channel_en_1 <= 1'b0;
            channel_en_2 <= 1'b0;
            con_en       <= 1'b0;
            con_sel      <= 1'b0;
            dma_ack      <= 2'b00;
            busy         <= 1'b0;
            grant_err    <= 1'b0;
        end else begin
            con_en    <= 1'b0;
            dma_ack   <= 2'b00;
            grant_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_config && pending != 2'b00) begin
                        con_sel <= winner;
                        con_en  <= 1'b1;
                        hbusreq <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= REQ_BUS;
                    end
                end
                REQ_BUS: begin
                    if (hgrant) begin
                        channel_en_1 <= ~con_sel;
                        channel_en_2 <= con_sel;
                        state        <= ACTIVE;
                    end else if (TO_EN && cnt == CNT_LAST) begin
                        grant_err <= 1'b1;
                        hbusreq   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (TO_EN) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    // Locked burst: only irq ends the transfer.
                    if (irq) begin
                        channel_en_1 <= 1'b0;
                        channel_en_2 <= 1'b0;
                        hbusreq      <= 1'b0;
                        dma_ack      <= con_sel ? 2'b10 : 2'b01;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_request_arbiter.sv
// Randomized bench for dmac_request_arbiter: transaction-level model feeds an event scoreboard.
module tb_dmac_request_arbiter;

    localparam int TO = 16;
    localparam int EV_START = 0, EV_EN = 1, EV_ACK = 2, EV_ERR = 3;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_XFER = 2, PH_ACK = 3;

    typedef struct {
        int kind;
        int ch;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dma_req;
    logic       c_config, irq, hgrant;
    logic       hbusreq, channel_en_1, channel_en_2, con_en, con_sel, busy, grant_err;
    logic [1:0] dma_ack;

    int checks = 0;
    int failures = 0;
    ev_t q[$];

    // model state
    int  m_ph = PH_IDLE;
    int  m_ch = 0;
    int  m_waited = 0;
    bit  m_pend[2];
    bit  m_last = 1'b0;
    bit  prev_en1 = 1'b0, prev_en2 = 1'b0;

    dmac_request_arbiter #(.GRANT_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .dma_req(dma_req), .c_config(c_config), .irq(irq),
        .hgrant(hgrant), .hbusreq(hbusreq), .channel_en_1(channel_en_1),
        .channel_en_2(channel_en_2), .con_en(con_en), .con_sel(con_sel),
        .dma_ack(dma_ack), .busy(busy), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input int kind, input int ch);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d ch %0d, none expected at %0t", kind, ch, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind != EV_ERR && e.ch != ch)) begin
                failures++;
                $display("FAIL event: got kind %0d ch %0d expected kind %0d ch %0d at %0t",
                         kind, ch, e.kind, e.ch, $time);
            end
        end
    endtask

    function automatic int pick_winner();
        if (m_pend[0] && m_pend[1]) begin
`ifdef DMAC_ARB_ROUND_ROBIN_EN
            return m_last ? 0 : 1;
`else
            return 0;
`endif
        end
        return m_pend[0] ? 0 : 1;
    endfunction

    // Reference model: one protocol step per clock, decisions taken on pre-edge pending.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ph = PH_IDLE; m_ch = 0; m_waited = 0; m_last = 1'b0;
                m_pend[0] = 1'b0; m_pend[1] = 1'b0;
                q.delete();
            end else begin
                bit [1:0] req_now;
                int served;
                req_now = dma_req;
                served = -1;
                case (m_ph)
                    PH_IDLE: if (c_config && (m_pend[0] || m_pend[1])) begin
                        m_ch = pick_winner();
                        m_waited = 0;
                        m_ph = PH_WAIT;
                        q.push_back('{EV_START, m_ch});
                    end
                    PH_WAIT: if (hgrant) begin
                        m_ph = PH_XFER;
                        q.push_back('{EV_EN, m_ch});
                    end else begin
                        m_waited++;
                        if (TO != 0 && m_waited == TO) begin
                            m_ph = PH_IDLE;
                            q.push_back('{EV_ERR, 0});
                        end
                    end
                    PH_XFER: if (irq) begin
                        m_ph = PH_ACK;
                        q.push_back('{EV_ACK, m_ch});
                    end
                    default: begin
                        served = m_ch;
                        m_last = (m_ch == 1);
                        m_ph = PH_IDLE;
                    end
                endcase
                for (int i = 0; i < 2; i++) begin
                    if (served == i) m_pend[i] = 1'b0;
                    if (req_now[i]) m_pend[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: level checks every cycle, pulse events popped from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            chk("hbusreq", int'(hbusreq), int'(m_ph == PH_WAIT || m_ph == PH_XFER));
            chk("busy", int'(busy), int'(m_ph != PH_IDLE));
            chk("channel_en_1", int'(channel_en_1), int'(m_ph == PH_XFER && m_ch == 0));
            chk("channel_en_2", int'(channel_en_2), int'(m_ph == PH_XFER && m_ch == 1));
            if (m_ph != PH_IDLE) chk("con_sel", int'(con_sel), m_ch);
            if (!rst) begin
                if (con_en) pop_cmp(EV_START, int'(con_sel));
                if (channel_en_1 && !prev_en1) pop_cmp(EV_EN, 0);
                if (channel_en_2 && !prev_en2) pop_cmp(EV_EN, 1);
                if (dma_ack != 2'b00) pop_cmp(EV_ACK, (dma_ack == 2'b01) ? 0 : (dma_ack == 2'b10) ? 1 : 9);
                if (grant_err) pop_cmp(EV_ERR, 0);
                if (q.size() != 0) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_event: %0d expected event(s) not seen, first kind %0d ch %0d at %0t",
                             q.size(), q[0].kind, q[0].ch, $time);
                    q.delete();
                end
            end
            prev_en1 = channel_en_1;
            prev_en2 = channel_en_2;
        end
    end

    task automatic run(input int cycles, input int p_req, input int p_gnt, input int p_irq, input int p_cfg);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            dma_req[0] = ($urandom_range(99) < p_req);
            dma_req[1] = ($urandom_range(99) < p_req);
            hgrant     = ($urandom_range(99) < p_gnt);
            irq        = ($urandom_range(99) < p_irq);
            c_config   = ($urandom_range(99) < p_cfg);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; dma_req = 2'b00; c_config = 1'b0; irq = 1'b0; hgrant = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dma_ack", int'(dma_ack), 0);
        chk("reset_con_en", int'(con_en), 0);
        chk("reset_grant_err", int'(grant_err), 0);
        rst = 1'b0;

        // simultaneous requests, both served back to back
        @(negedge clk); c_config = 1'b1; hgrant = 1'b1; dma_req = 2'b11;
        @(negedge clk); dma_req = 2'b00;
        run(40, 0, 100, 30, 100);

        run(200, 10, 60, 25, 90);
        // grant never arrives: repeated timeouts with pending retained
        run(60, 30, 0, 25, 100);
        // controller unconfigured: requests accumulate, nothing starts
        run(40, 20, 50, 25, 0);
        run(300, 40, 70, 20, 85);

        // reset in the middle of a transfer
        @(negedge clk); dma_req = 2'b01; c_config = 1'b1; hgrant = 1'b1; irq = 1'b0;
        @(negedge clk); dma_req = 2'b10;
        @(negedge clk); dma_req = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = channel_en_1 | channel_en_2;
        end
        chk("active_before_reset", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_channel_en", int'({channel_en_2, channel_en_1}), 0);
        chk("async_rst_hbusreq", int'(hbusreq), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_dma_ack", int'(dma_ack), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // pending must have been dropped: no transfer may start without new requests
        run(20, 0, 100, 30, 100);

        run(250, 25, 50, 30, 90);
        dma_req = 2'b00;
        run(40, 0, 100, 40, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
